// File: rtl/msk_tx_scheduler.sv
// Frame scheduler for the MSK modulator: round-robin grant between two byte requesters,
// then preamble, length and payload bytes, re-arming the modulator with a reset pulse per byte.
module msk_tx_scheduler #(
  parameter int unsigned           DATA_WIDTH      = 8,
  parameter int unsigned           SAMPLES_PER_BIT = 32,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE        = 8'hAA,
  parameter int unsigned           PREAMBLE_LEN    = 2
) (
  input  logic                  G_CLK_TX,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [7:0]            len0,
  input  logic [7:0]            len1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [1:0]            valid,
  output logic [1:0]            ready,
  output logic [1:0]            grant,
  output logic                  mod_enable,
  output logic                  mod_reset,
  output logic [DATA_WIDTH-1:0] mod_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int unsigned      BYTE_CYCLES = 8 * SAMPLES_PER_BIT;
  localparam int unsigned      CNT_W       = $clog2(BYTE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BYTE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;
  typedef enum logic [1:0] {PH_PRE, PH_LEN, PH_PAY} phase_t;

  state_t                state, state_nxt;
  phase_t                phase, phase_nxt;
  logic [3:0]            pre_cnt, pre_cnt_nxt;
  logic [7:0]            len_q, len_q_nxt;
  logic [7:0]            pay_cnt, pay_cnt_nxt;
  logic [CNT_W-1:0]      smp_cnt, smp_cnt_nxt;
  logic                  sel, sel_nxt;
  logic                  rr_last, rr_last_nxt;
  logic [1:0]            ready_nxt, grant_nxt;
  logic                  mod_enable_nxt, mod_reset_nxt;
  logic                  busy_nxt, frame_done_nxt, underrun_nxt;
  logic [DATA_WIDTH-1:0] mod_data_nxt;
  logic                  pick, take, sel_vld, last_byte;
  logic [DATA_WIDTH-1:0] byte_sel;

  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    pre_cnt_nxt    = pre_cnt;
    len_q_nxt      = len_q;
    pay_cnt_nxt    = pay_cnt;
    smp_cnt_nxt    = smp_cnt;
    sel_nxt        = sel;
    rr_last_nxt    = rr_last;
    ready_nxt      = 2'b00;
    grant_nxt      = grant;
    mod_enable_nxt = mod_enable;
    mod_reset_nxt  = mod_reset;
    mod_data_nxt   = mod_data;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    underrun_nxt   = underrun;
    pick           = 1'b0;
    take           = 1'b0;
    byte_sel       = '0;
    sel_vld        = sel ? valid[1] : valid[0];
    last_byte      = (phase == PH_PAY) && (pay_cnt == 8'd0);

    case (state)
      S_IDLE: begin
        mod_reset_nxt  = 1'b0;
        mod_enable_nxt = 1'b0;
        if (|req) begin
          // Contention goes to whichever requester did not win last time.
          pick         = (req == 2'b11) ? ~rr_last : req[1];
          sel_nxt      = pick;
          rr_last_nxt  = pick;
          grant_nxt    = pick ? 2'b10 : 2'b01;
          len_q_nxt    = pick ? len1 : len0;
          pay_cnt_nxt  = pick ? len1 : len0;
          pre_cnt_nxt  = 4'(PREAMBLE_LEN);
          phase_nxt    = PH_PRE;
          busy_nxt     = 1'b1;
          underrun_nxt = 1'b0;
          state_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        case (phase)
          PH_PRE: begin
            take        = 1'b1;
            byte_sel    = PREAMBLE;
            pre_cnt_nxt = pre_cnt - 4'd1;
            if (pre_cnt == 4'd1) phase_nxt = PH_LEN;
          end
          PH_LEN: begin
            take      = 1'b1;
            byte_sel  = DATA_WIDTH'(len_q);
            phase_nxt = PH_PAY;
          end
          default: begin
            if (sel_vld) begin
              take        = 1'b1;
              byte_sel    = sel ? data1 : data0;
              ready_nxt   = sel ? 2'b10 : 2'b01;
              pay_cnt_nxt = pay_cnt - 8'd1;
            end else begin
              underrun_nxt = 1'b1;
            end
          end
        endcase
        if (take) begin
          mod_data_nxt   = byte_sel;
          mod_reset_nxt  = 1'b1;
          mod_enable_nxt = 1'b1;
          smp_cnt_nxt    = '0;
          state_nxt      = S_SEND;
        end
      end
      S_SEND: begin
        if (smp_cnt == CNT_LAST) begin
          // Drop reset together with enable so the GAP cycle re-arms the modulator.
          mod_enable_nxt = 1'b0;
          mod_reset_nxt  = 1'b0;
          frame_done_nxt = last_byte;
          state_nxt      = S_GAP;
        end else begin
          smp_cnt_nxt = smp_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (last_byte) begin
          grant_nxt = 2'b00;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge G_CLK_TX or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      phase      <= PH_PRE;
      pre_cnt    <= '0;
      len_q      <= '0;
      pay_cnt    <= '0;
      smp_cnt    <= '0;
      sel        <= 1'b0;
      rr_last    <= 1'b1;
      ready      <= 2'b00;
      grant      <= 2'b00;
      mod_enable <= 1'b0;
      mod_reset  <= 1'b0;
      mod_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      pre_cnt    <= pre_cnt_nxt;
      len_q      <= len_q_nxt;
      pay_cnt    <= pay_cnt_nxt;
      smp_cnt    <= smp_cnt_nxt;
      sel        <= sel_nxt;
      rr_last    <= rr_last_nxt;
      ready      <= ready_nxt;
      grant      <= grant_nxt;
      mod_enable <= mod_enable_nxt;
      mod_reset  <= mod_reset_nxt;
      mod_data   <= mod_data_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      underrun   <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_msk_tx_scheduler.sv
// Bench for msk_tx_scheduler: random payloads, frame-level model of the byte stream,
// cycle budgets and modulator handshake rules.
module tb_msk_tx_scheduler;

  localparam int         PL     = 2;
  localparam logic [7:0] PRE    = 8'hAA;
  localparam int         BC     = 256;
  localparam int         BYTE_T = BC + 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req;
  logic [7:0] len0, len1;
  logic [7:0] data0, data1;
  logic [1:0] valid, ready, grant;
  logic       mod_enable, mod_reset, busy, frame_done, underrun;
  logic [7:0] mod_data;
  logic       stall0;

  logic [7:0] pay0 [1024];
  logic [7:0] pay1 [1024];
  logic [9:0] idx0 = '0;
  logic [9:0] idx1 = '0;

  assign data0 = pay0[idx0];
  assign data1 = pay1[idx1];
  assign valid = {1'b1, ~stall0};

  int checks = 0;
  int errors = 0;

  msk_tx_scheduler dut (
    .G_CLK_TX  (clk),
    .reset     (rst_n),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .data0     (data0),
    .data1     (data1),
    .valid     (valid),
    .ready     (ready),
    .grant     (grant),
    .mod_enable(mod_enable),
    .mod_reset (mod_reset),
    .mod_data  (mod_data),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun)
  );

  initial forever #5 clk = ~clk;

  // Frame observer: bytes sent, enable run lengths, handshake rule violations.
  logic [7:0] sent_q [$];
  int         busy_cyc, low_cyc, rdy_cnt, runs_bad, en_viol, gap_viol, stab_viol;
  int         grant_rises, first_lat, run_len;
  logic       prev_en = 1'b0, prev_rst = 1'b0, prev_busy = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      sent_q.delete();
      busy_cyc = 0; low_cyc = 0; rdy_cnt = 0; runs_bad = 0;
      en_viol = 0; gap_viol = 0; stab_viol = 0; grant_rises = 0; first_lat = -1;
    end
    if (grant != 2'b00 && prev_grant == 2'b00) grant_rises++;
    if (busy) busy_cyc++;
    if (busy && !mod_enable && !mod_reset) low_cyc++;
    if (mod_enable && !mod_reset) en_viol++;
    if (mod_enable && !prev_en) begin
      if (sent_q.size() == 0) first_lat = busy_cyc;
      sent_q.push_back(mod_data);
      if (prev_rst) gap_viol++;
      run_len = 1;
    end else if (mod_enable) begin
      run_len++;
      if (mod_data != prev_data) stab_viol++;
    end
    if (!mod_enable && prev_en && run_len != BC) runs_bad++;
    if (ready[0]) begin idx0++; rdy_cnt++; end
    if (ready[1]) begin idx1++; rdy_cnt++; end
    prev_en    = mod_enable;
    prev_rst   = mod_reset;
    prev_busy  = busy;
    prev_grant = grant;
    prev_data  = mod_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic grab();
    int c;
    c = 0;
    while (grant === 2'b00 && c < 20) begin @(negedge clk); c++; end
    check("grant_latency", c, 1);
  endtask

  task automatic poll_ready0();
    int c;
    c = 0;
    while (ready[0] !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
    check("ready0_seen", 32'(ready[0]), 1);
  endtask

  // Model: frame = PL preambles, length byte, then the owner's next len payload bytes.
  task automatic wait_frame(input int eg, input int el, input int extra, input int r, input int base);
    int         c, nb, bad;
    logic [7:0] exp_q [$];
    nb = PL + 1 + el;
    for (int i = 0; i < PL; i++) exp_q.push_back(PRE);
    exp_q.push_back(8'(el));
    for (int i = 0; i < el; i++)
      exp_q.push_back(r == 0 ? pay0[10'(base + i)] : pay1[10'(base + i)]);
    c = 0;
    while (frame_done !== 1'b1 && c < nb * BYTE_T + extra + 600) begin @(negedge clk); c++; end
    #1;
    check("frame_done_seen", 32'(frame_done), 1);
    check("frame_grant", 32'(grant), eg);
    check("byte_count", sent_q.size(), nb);
    bad = 0;
    for (int i = 0; i < nb; i++) begin
      if (i >= sent_q.size()) bad++;
      else if (sent_q[i] !== exp_q[i]) bad++;
    end
    check("byte_mismatches", bad, 0);
    check("enable_runs_not_256", runs_bad, 0);
    check("ready_pulses", rdy_cnt, el);
    check("busy_cycles", busy_cyc, nb * BYTE_T + extra);
    check("low_cycles", low_cyc, 2 * nb + extra);
    check("enable_while_reset_low", en_viol, 0);
    check("no_reset_gap", gap_viol, 0);
    check("data_unstable", stab_viol, 0);
    check("first_byte_latency", first_lat, 2);
    check("grants_in_frame", grant_rises, 1);
    @(negedge clk);
  endtask

  initial begin
    int         b0, b1, l1;
    logic [7:0] got [4];
    req = 2'b00; len0 = 8'd0; len1 = 8'd0; stall0 = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      pay0[i] = 8'($urandom);
      pay1[i] = 8'($urandom);
    end
    pay0[0] = 8'h5C;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_mod_enable", 32'(mod_enable), 0);
    check("rst_mod_reset", 32'(mod_reset), 0);
    check("rst_mod_data", 32'(mod_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_underrun", 32'(underrun), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Single payload byte from requester 0
    len0 = 8'd1; b0 = int'(idx0); req = 2'b01;
    grab();
    check("t1_busy_at_grant", 32'(busy), 1);
    req = 2'b00;
    wait_frame(1, 1, 0, 0, b0);
    for (int i = 0; i < 4; i++) got[i] = (i < sent_q.size()) ? sent_q[i] : 8'h00;
    check("t1_byte0", 32'(got[0]), 32'hAA);
    check("t1_byte1", 32'(got[1]), 32'hAA);
    check("t1_byte2", 32'(got[2]), 32'h01);
    check("t1_byte3", 32'(got[3]), 32'h5C);

    // Random-length frame from requester 1
    l1 = int'($urandom_range(4, 1)); b1 = int'(idx1); len1 = 8'(l1); req = 2'b10;
    grab();
    req = 2'b00;
    wait_frame(2, l1, 0, 1, b1);

    // Round robin with both requesting, zero-length frames
    len0 = 8'd0; len1 = 8'd0; req = 2'b11;
    wait_frame(1, 0, 0, 0, int'(idx0));
    wait_frame(2, 0, 0, 1, int'(idx1));
    @(negedge clk);
    check("rr_third_grant", 32'(grant), 1);
    req = 2'b00;
    wait_frame(1, 0, 0, 0, int'(idx0));

    // Payload underrun before the second payload byte
    len0 = 8'd3; b0 = int'(idx0); req = 2'b01;
    grab();
    req = 2'b00;
    poll_ready0();
    begin
      int c;
      c = 0;
      while (mod_enable !== 1'b0 && c < 400) begin @(negedge clk); c++; end
      check("first_pay_byte_ends", 32'(mod_enable), 0);
    end
    stall0 = 1'b1;
    repeat (11) @(negedge clk);
    check("underrun_set", 32'(underrun), 1);
    check("underrun_hold_enable", 32'(mod_enable), 0);
    check("underrun_hold_reset", 32'(mod_reset), 0);
    stall0 = 1'b0;
    wait_frame(1, 3, 10, 0, b0);
    check("underrun_sticky", 32'(underrun), 1);

    // Maximum length; underrun clears at grant
    len0 = 8'd255; b0 = int'(idx0); req = 2'b01;
    grab();
    check("underrun_cleared", 32'(underrun), 0);
    req = 2'b00;
    wait_frame(1, 255, 0, 0, b0);

    // req/len changes mid-frame are ignored
    len0 = 8'd2; b0 = int'(idx0); req = 2'b01;
    grab();
    l1 = int'($urandom_range(3, 0)); b1 = int'(idx1);
    len0 = 8'd200; len1 = 8'(l1); req = 2'b10;
    repeat (300) @(negedge clk);
    check("midframe_grant", 32'(grant), 1);
    wait_frame(1, 2, 0, 0, b0);
    @(negedge clk);
    check("next_grant", 32'(grant), 2);
    req = 2'b00;
    wait_frame(2, l1, 0, 1, b1);

    // Reset during the 100th SEND cycle of a payload byte
    len0 = 8'd2; req = 2'b01;
    grab();
    req = 2'b00;
    poll_ready0();
    repeat (99) @(negedge clk);
    check("pre_reset_enable", 32'(mod_enable), 1);
    rst_n = 1'b0; req = 2'b11; len0 = 8'd0; len1 = 8'd0;
    #1;
    check("midrst_grant", 32'(grant), 0);
    check("midrst_ready", 32'(ready), 0);
    check("midrst_mod_enable", 32'(mod_enable), 0);
    check("midrst_mod_reset", 32'(mod_reset), 0);
    check("midrst_mod_data", 32'(mod_data), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_frame_done", 32'(frame_done), 0);
    check("midrst_underrun", 32'(underrun), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    grab();
    check("post_reset_grant", 32'(grant), 1);
    req = 2'b00;
    wait_frame(1, 0, 0, 0, int'(idx0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msk_tx_scheduler.md
# msk_tx_scheduler

Frame-level controller for the MSK modulator. It arbitrates round-robin between two byte-stream requesters and builds each frame from preamble bytes, a length byte and the payload. It then feeds the modulator one byte at a time, driving its `enable`, active-low `reset` and `data_in`. It re-arms the modulator with a one-cycle reset pulse between bytes, because the modulator stops after 8 bits.

## Interface
- `DATA_WIDTH`, 8: byte width of the modulator and requester data.
- `SAMPLES_PER_BIT`, 32: modulator output samples per bit.
- `PREAMBLE`, 8'hAA: preamble byte value.
- `PREAMBLE_LEN`, 2: number of preamble bytes per frame (1..15).

Ports:
- `G_CLK_TX`  in  1  transmit clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req[1:0]`  in  2  frame request per requester; held high until granted.
- `len0`, `len1`  in  8 each  payload byte count of requester 0/1, sampled at grant.
- `data0`, `data1`  in  DATA_WIDTH each  payload byte of requester 0/1.
- `valid[1:0]`  in  2  payload byte available.
- `ready[1:0]`  out  2  one-cycle pulse: byte consumed from that requester.
- `grant[1:0]`  out  2  one-hot owner of the current frame; 0 when idle.
- `mod_enable`  out  1  to modulator `enable`.
- `mod_reset`  out  1  to modulator `reset` (active-low).
- `mod_data`  out  DATA_WIDTH  to modulator `data_in`.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `underrun`  out  1  sticky; set when a payload byte was late; cleared at next grant.

## Operation
- All outputs are registered. Reset values:
  - `grant`=0, `ready`=0, `mod_enable`=0, `mod_reset`=0, `mod_data`=0.
  - `busy`=0, `frame_done`=0, `underrun`=0.
  - State IDLE, round-robin pointer = requester 0 preferred.
- `BYTE_CYCLES` = 8*`SAMPLES_PER_BIT` (256). The sample counter is 9 bits for the default.
- IDLE:
  - `mod_reset`=0, `mod_enable`=0.
  - If any `req` is high, grant one requester, latch its `len` into a byte counter, set `busy`, clear `underrun`, then go to LOAD with phase PRE.
  - If both requesters are high, grant the one not granted last; the pointer updates on each grant.
- LOAD selects the next byte and asserts `mod_reset`=1 when the byte is taken:
  - PRE phase: `PREAMBLE`, repeated `PREAMBLE_LEN` times.
  - LEN phase: the latched length.
  - PAY phase: the granted requester's data, taken only when its `valid`=1; `ready` pulses for that one cycle.
  - Then go to SEND.
- PAY underrun: if `valid`=0 in LOAD, stay in LOAD with `mod_reset`=0 and `mod_enable`=0, and set `underrun`. There is no timeout.
- SEND:
  - `mod_enable`=1 for exactly `BYTE_CYCLES` consecutive cycles.
  - `mod_data` is stable for the whole byte.
  - On the last count, go to GAP.
- GAP:
  - `mod_enable`=0, `mod_reset`=0 for exactly one cycle.
  - If bytes remain, go to LOAD.
  - Otherwise pulse `frame_done`, clear `grant` and `busy`, and go to IDLE.
- `len`=0 gives a frame of preamble plus the length byte only; `ready` never pulses.
- `len`=255 sends 255 payload bytes. The byte counter does not wrap.
- `req` and `len` changes during a frame are ignored; they are sampled only in IDLE.
- `valid`/`data` of the non-granted requester are ignored.
- Reset asserted mid-frame drops the frame immediately; all outputs take their reset values.

## Timing
- Request to grant: `req` high in IDLE at edge k gives `grant`/`busy` at k+1.
- The first byte's `mod_reset`=1 and `mod_enable`=1 appear by k+2.
- Per byte with no underrun: 1 LOAD + 256 SEND + 1 GAP = 258 cycles.
- Frame length = (`PREAMBLE_LEN`+1+`len`)*258 cycles, plus one IDLE cycle before the next grant.
- `mod_reset` is low for at least one cycle between any two bytes. `mod_enable` is never high while `mod_reset` is low.
- `ready` pulses in the same cycle `mod_data` loads that byte.
- `frame_done` coincides with the last GAP cycle.

## Test plan
- Reset, then `req`=2'b01, `len0`=1, `data0`=8'h5C always valid:
  - `mod_data` sequence AA, AA, 01, 5C, each with `mod_enable` high 256 cycles and one `mod_reset` low cycle between.
  - One `ready[0]` pulse; `frame_done` 1032 cycles after grant.
- `req`=2'b11 with `len`=0 for both requesters: grant order 01, 10, 01 over three frames. Each frame is 3 bytes (774 cycles).
- `len0`=3, `valid[0]` dropped for 10 cycles before the second payload byte:
  - LOAD holds 10 extra cycles with `mod_enable`=0 and `mod_reset`=0; `underrun`=1.
  - `underrun` clears at the next grant.
- `len0`=255: exactly 255 `ready` pulses and 258 bytes sent; no wrap to a zero count.
- Assert `reset` during the 100th SEND cycle of a payload byte:
  - All outputs at reset values within the same cycle (async).
  - After release, a pending `req[1]` is granted first only if the pointer says so; the post-reset default is requester 0.
- Change `len0` and `req` mid-frame: frame length is unchanged and no extra grant occurs.
